// File: rtl/sm3_cmprss_core_unrl.sv
// sm3_cmprss_core_unrl
//   SM3 compression core running UNROLL chained rounds per accepted input beat.
//   Takes the (Wj, Wj') stream from the expansion core, chains 512-bit blocks
//   through the V register and presents the 256-bit digest on a valid/ready port.
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   expnd_inpt_wj_i      Wj lanes, lane k (round j+k) at [32*(UNROLL-1-k)+:32]
//   expnd_inpt_wjj_i     Wj' lanes, same order
//   expnd_inpt_lst_i     final beat of the message (looked at on a block's last beat only)
//   expnd_inpt_vld_i     input beat valid
//   expnd_inpt_rdy_o     input ready
//   cmprss_otpt_res_o    digest V0..V7, V0 in [255:224]
//   cmprss_otpt_vld_o    digest valid
//   cmprss_otpt_rdy_i    downstream ready
//   dbg_state            current FSM state (RUN=0, UPDT=1, OUT=2)
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high. A valid source holds its data stable until the transfer; ready may
// rise or fall freely and never depends combinationally on valid.
//
// UNROLL must be 1, 2, 4 or 8 so that 64 rounds split into whole beats.
module sm3_cmprss_core_unrl #(
  parameter int UNROLL = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [32*UNROLL-1:0]  expnd_inpt_wj_i,
  input  logic [32*UNROLL-1:0]  expnd_inpt_wjj_i,
  input  logic                  expnd_inpt_lst_i,
  input  logic                  expnd_inpt_vld_i,
  output logic                  expnd_inpt_rdy_o,
  output logic [255:0]          cmprss_otpt_res_o,
  output logic                  cmprss_otpt_vld_o,
  input  logic                  cmprss_otpt_rdy_i,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    UPDT = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [255:0] IV = {32'h7380166f, 32'h4914b2b9, 32'h172442d7, 32'hda8a0600,
                                 32'ha96f30bc, 32'h163138aa, 32'he38dee4d, 32'hb0fb0e4e};
  localparam logic [5:0] STEP     = 6'(UNROLL);
  localparam logic [5:0] LAST_RND = 6'(64 - UNROLL);

  // Rotate via a doubled word so a zero amount needs no special case.
  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] s);
    logic [63:0] d;
    d = {x, x} << s;
    return d[63:32];
  endfunction

  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rotl(x, 5'd9) ^ rotl(x, 5'd17);
  endfunction

  // One SM3 round on {A,B,C,D,E,F,G,H}.
  function automatic logic [255:0] sm3_round(input logic [255:0] s, input logic [5:0] j,
                                             input logic [31:0] wj, input logic [31:0] wjj);
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] tj, a12, ss1, ss2, ff, gg, tt1, tt2;
    {a, b, c, d, e, f, g, h} = s;
    tj  = (j < 6'd16) ? 32'h79cc4519 : 32'h7a879d8a;
    a12 = rotl(a, 5'd12);
    // Tj rotation is by j mod 32, i.e. the low five bits of j.
    ss1 = rotl(a12 + e + rotl(tj, j[4:0]), 5'd7);
    ss2 = ss1 ^ a12;
    ff  = (j < 6'd16) ? (a ^ b ^ c) : ((a & b) | (a & c) | (b & c));
    gg  = (j < 6'd16) ? (e ^ f ^ g) : ((e & f) | (~e & g));
    tt1 = ff + d + ss2 + wjj;
    tt2 = gg + h + ss1 + wj;
    return {tt1, a, rotl(b, 5'd9), c, p0(tt2), e, rotl(f, 5'd19), g};
  endfunction

  state_t       state_q, state_d;
  logic [255:0] v_q;
  logic [255:0] st_q;      // working variables A..H
  logic [5:0]   rnd_q;
  logic         lst_q;
  logic [255:0] rnd_work;  // A..H after this beat's UNROLL rounds

  always_comb begin
    rnd_work = st_q;
    for (int k = 0; k < UNROLL; k++) begin
      rnd_work = sm3_round(rnd_work, rnd_q + 6'(k),
                           expnd_inpt_wj_i[32*(UNROLL-1-k) +: 32],
                           expnd_inpt_wjj_i[32*(UNROLL-1-k) +: 32]);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (expnd_inpt_vld_i && rnd_q == LAST_RND) state_d = UPDT;
      UPDT:    state_d = lst_q ? OUT : RUN;
      OUT:     if (cmprss_otpt_rdy_i) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Outputs are forced low during reset, even before the state register clears.
  always_comb begin
    expnd_inpt_rdy_o  = ~rst && (state_q == RUN);
    cmprss_otpt_vld_o = ~rst && (state_q == OUT);
    cmprss_otpt_res_o = cmprss_otpt_vld_o ? v_q : '0;
    dbg_state         = state_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      v_q     <= IV;
      st_q    <= IV;
      rnd_q   <= '0;
      lst_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        RUN: begin
          if (expnd_inpt_vld_i) begin
            st_q  <= rnd_work;
            rnd_q <= rnd_q + STEP;   // wraps to 0 after the last beat
            if (rnd_q == LAST_RND) lst_q <= expnd_inpt_lst_i;
          end
        end
        UPDT: begin
          // A..H restart from the new V so the next block chains directly.
          v_q  <= v_q ^ st_q;
          st_q <= v_q ^ st_q;
        end
        OUT: begin
          if (cmprss_otpt_rdy_i) begin
            v_q   <= IV;
            st_q  <= IV;
            lst_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sm3_cmprss_core_unrl.sv
module tb_sm3_cmprss_core_unrl;

  localparam int U     = 4;
  localparam int BEATS = 64 / U;

  localparam logic [255:0] DIG_ABC = {32'h66c7f0f4, 32'h62eeedd9, 32'hd1f2d46b, 32'hdc10e4e2,
                                      32'h4167c487, 32'h5cf2f7a2, 32'h297da02b, 32'h8f4ba8e0};
  localparam logic [255:0] DIG_TWO = {32'hdebe9ff9, 32'h2275b8a1, 32'h38604889, 32'hc18e5a4d,
                                      32'h6fdb70e5, 32'h387e5765, 32'h293dcba3, 32'h9c0c5732};
  localparam logic [511:0] BLK_ABC  = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_TWO1 = {16{32'h61626364}};
  localparam logic [511:0] BLK_TWO2 = {32'h80000000, 448'h0, 32'h00000200};

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // UNROLL=4 instance
  logic [32*U-1:0] wj = '0, wjj = '0;
  logic            lst = 1'b0, vld = 1'b0, rdy_i = 1'b1;
  logic            rdy_o, vld_o;
  logic [255:0]    res;
  logic [1:0]      dbg;

  sm3_cmprss_core_unrl #(.UNROLL(U)) dut (
    .clk(clk), .rst(rst),
    .expnd_inpt_wj_i(wj), .expnd_inpt_wjj_i(wjj),
    .expnd_inpt_lst_i(lst), .expnd_inpt_vld_i(vld), .expnd_inpt_rdy_o(rdy_o),
    .cmprss_otpt_res_o(res), .cmprss_otpt_vld_o(vld_o), .cmprss_otpt_rdy_i(rdy_i),
    .dbg_state(dbg)
  );

  // UNROLL=1 instance
  logic [31:0]  u1_wj = '0, u1_wjj = '0;
  logic         u1_lst = 1'b0, u1_vld = 1'b0, u1_rdy_i = 1'b1;
  logic         u1_rdy_o, u1_vld_o;
  logic [255:0] u1_res;
  logic [1:0]   u1_dbg;

  sm3_cmprss_core_unrl #(.UNROLL(1)) dut_u1 (
    .clk(clk), .rst(rst),
    .expnd_inpt_wj_i(u1_wj), .expnd_inpt_wjj_i(u1_wjj),
    .expnd_inpt_lst_i(u1_lst), .expnd_inpt_vld_i(u1_vld), .expnd_inpt_rdy_o(u1_rdy_o),
    .cmprss_otpt_res_o(u1_res), .cmprss_otpt_vld_o(u1_vld_o), .cmprss_otpt_rdy_i(u1_rdy_i),
    .dbg_state(u1_dbg)
  );

  int total = 0;
  int bad   = 0;

  // Expansion of the current block (message schedule model)
  logic [31:0] w  [0:67];
  logic [31:0] wp [0:63];

  function automatic logic [31:0] rl(input logic [31:0] x, input int s);
    return (x << s) | (x >> (32 - s));
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rl(x, 15) ^ rl(x, 23);
  endfunction

  task automatic load_block(input logic [511:0] m);
    for (int i = 0; i < 16; i++) w[i] = m[511-32*i -: 32];
    for (int j = 16; j < 68; j++)
      w[j] = p1(w[j-16] ^ w[j-9] ^ rl(w[j-3], 15)) ^ rl(w[j-13], 7) ^ w[j-6];
    for (int j = 0; j < 64; j++) wp[j] = w[j] ^ w[j+4];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: sends nbeats beats of the loaded block to the UNROLL=4 instance.
  task automatic send_block(input bit last, input bit gaps, input bit mid_lst, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      int g;
      int n;
      if (gaps) begin
        g   = $urandom_range(0, 3);
        vld = 1'b0;
        wj  = 32*U'($urandom);
        repeat (g) step();
      end
      for (int k = 0; k < U; k++) begin
        wj[32*(U-1-k) +: 32]  = w[U*b+k];
        wjj[32*(U-1-k) +: 32] = wp[U*b+k];
      end
      lst = (b == BEATS-1) ? last : (mid_lst ? 1'($urandom_range(0, 1)) : 1'b0);
      vld = 1'b1;
      n = 0;
      while (!rdy_o && n < 200) begin
        step();
        n++;
      end
      total++;
      if (rdy_o !== 1'b1) begin
        bad++;
        $display("FAIL rdy_wait beat=%0d rdy_o=%b required=1", b, rdy_o);
      end
      step();
    end
    vld = 1'b0;
    lst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    total++;
    if (rdy_o !== 1'b0 || vld_o !== 1'b0 || res !== 256'h0) begin
      bad++;
      $display("FAIL reset_outputs rdy=%b vld=%b res=%h required 0/0/0", rdy_o, vld_o, res);
    end
    rst = 1'b0;
    #1;
    total++;
    if (rdy_o !== 1'b1 || dbg !== 2'd0 || u1_rdy_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_release rdy=%b dbg=%0d u1_rdy=%b required 1/0/1", rdy_o, dbg, u1_rdy_o);
    end
  endtask

  task automatic test_abc();
    load_block(BLK_ABC);
    send_block(1'b1, 1'b0, 1'b0, BEATS);
    total++;
    if (vld_o !== 1'b0 || rdy_o !== 1'b0 || dbg !== 2'd1) begin
      bad++;
      $display("FAIL abc_updt vld=%b rdy=%b dbg=%0d required 0/0/1", vld_o, rdy_o, dbg);
    end
    step();
    total++;
    if (vld_o !== 1'b1 || res !== DIG_ABC) begin
      bad++;
      $display("FAIL abc_digest vld=%b res=%h required 1/%h", vld_o, res, DIG_ABC);
    end
    step();
    total++;
    if (vld_o !== 1'b0 || rdy_o !== 1'b1) begin
      bad++;
      $display("FAIL abc_after vld=%b rdy=%b required 0/1", vld_o, rdy_o);
    end
  endtask

  task automatic test_two_block();
    load_block(BLK_TWO1);
    send_block(1'b0, 1'b0, 1'b0, BEATS);
    step();
    total++;
    if (vld_o !== 1'b0 || rdy_o !== 1'b1) begin
      bad++;
      $display("FAIL two_mid vld=%b rdy=%b required 0/1", vld_o, rdy_o);
    end
    load_block(BLK_TWO2);
    send_block(1'b1, 1'b0, 1'b0, BEATS);
    step();
    total++;
    if (vld_o !== 1'b1 || res !== DIG_TWO) begin
      bad++;
      $display("FAIL two_digest vld=%b res=%h required 1/%h", vld_o, res, DIG_TWO);
    end
    step();
  endtask

  task automatic test_gaps();
    load_block(BLK_ABC);
    send_block(1'b1, 1'b1, 1'b0, BEATS);
    step();
    total++;
    if (vld_o !== 1'b1 || res !== DIG_ABC) begin
      bad++;
      $display("FAIL gaps_digest vld=%b res=%h required 1/%h", vld_o, res, DIG_ABC);
    end
    step();
  endtask

  task automatic test_out_stall();
    int errs;
    load_block(BLK_ABC);
    rdy_i = 1'b0;
    send_block(1'b1, 1'b0, 1'b0, BEATS);
    step();
    // Offer a bogus beat while the digest is stalled; it must not be taken.
    wj   = {U{32'hdeadbeef}};
    wjj  = {U{32'h12345678}};
    vld  = 1'b1;
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (vld_o !== 1'b1 || res !== DIG_ABC || rdy_o !== 1'b0) begin
        bad++;
        errs++;
        if (errs < 3)
          $display("FAIL stall_hold cyc=%0d vld=%b rdy=%b res=%h required 1/0/%h",
                   i, vld_o, rdy_o, res, DIG_ABC);
      end
      step();
    end
    rdy_i = 1'b1;
    vld   = 1'b0;
    step();
    total++;
    if (vld_o !== 1'b0 || rdy_o !== 1'b1) begin
      bad++;
      $display("FAIL stall_release vld=%b rdy=%b required 0/1", vld_o, rdy_o);
    end
    send_block(1'b1, 1'b0, 1'b0, BEATS);
    step();
    total++;
    if (vld_o !== 1'b1 || res !== DIG_ABC) begin
      bad++;
      $display("FAIL stall_next_digest vld=%b res=%h required 1/%h", vld_o, res, DIG_ABC);
    end
    step();
  endtask

  task automatic test_reset_mid();
    load_block(BLK_ABC);
    send_block(1'b1, 1'b0, 1'b0, 5);   // rounds 0..19 done, beat at round 20 next
    rst = 1'b1;
    step();
    total++;
    if (vld_o !== 1'b0 || rdy_o !== 1'b0 || res !== 256'h0) begin
      bad++;
      $display("FAIL rstmid_during vld=%b rdy=%b res=%h required 0/0/0", vld_o, rdy_o, res);
    end
    step();
    rst = 1'b0;
    #1;
    total++;
    if (rdy_o !== 1'b1 || vld_o !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_release rdy=%b vld=%b required 1/0", rdy_o, vld_o);
    end
    send_block(1'b1, 1'b0, 1'b0, BEATS);
    step();
    total++;
    if (vld_o !== 1'b1 || res !== DIG_ABC) begin
      bad++;
      $display("FAIL rstmid_digest vld=%b res=%h required 1/%h", vld_o, res, DIG_ABC);
    end
    step();
  endtask

  task automatic test_back_to_back();
    load_block(BLK_ABC);
    for (int m = 0; m < 2; m++) begin
      send_block(1'b1, 1'b0, 1'b1, BEATS);
      step();
      total++;
      if (vld_o !== 1'b1 || res !== DIG_ABC) begin
        bad++;
        $display("FAIL b2b_digest msg=%0d vld=%b res=%h required 1/%h", m, vld_o, res, DIG_ABC);
      end
      step();
      total++;
      if (rdy_o !== 1'b1 || dbg !== 2'd0) begin
        bad++;
        $display("FAIL b2b_run msg=%0d rdy=%b dbg=%0d required 1/0", m, rdy_o, dbg);
      end
    end
  endtask

  task automatic test_u1_abc();
    int n;
    load_block(BLK_ABC);
    for (int j = 0; j < 64; j++) begin
      u1_wj  = w[j];
      u1_wjj = wp[j];
      u1_lst = (j == 63);
      u1_vld = 1'b1;
      n = 0;
      while (!u1_rdy_o && n < 200) begin
        step();
        n++;
      end
      step();
    end
    u1_vld = 1'b0;
    u1_lst = 1'b0;
    total++;
    if (u1_vld_o !== 1'b0) begin
      bad++;
      $display("FAIL u1_updt vld=%b required 0", u1_vld_o);
    end
    step();
    total++;
    if (u1_vld_o !== 1'b1 || u1_res !== DIG_ABC) begin
      bad++;
      $display("FAIL u1_digest vld=%b res=%h required 1/%h", u1_vld_o, u1_res, DIG_ABC);
    end
    step();
  endtask

  initial begin
    repeat (3) step();
    test_reset();
    test_abc();
    test_two_block();
    test_gaps();
    test_out_stall();
    test_reset_mid();
    test_back_to_back();
    test_u1_abc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
